// File: rtl/amp_pkg.sv
// Shared types and constants for the amplitude selector and decoder.
// Threshold helper sits midway between adjacent gain swings.
package amp_pkg;

    localparam int unsigned AMP_W = 11;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned THR_W = 12;

    typedef enum logic [SEL_W-1:0] {
        AMP_X1 = 2'b00,
        AMP_X2 = 2'b01,
        AMP_X3 = 2'b10,
        AMP_X4 = 2'b11
    } amp_code_e;

    typedef enum logic {
        StAcc,
        StEval
    } state_e;

    // k/2 times full scale, floored; k=3,5,7 gives the class boundaries.
    function automatic logic [THR_W-1:0] thr(input int unsigned full_scale, input int unsigned k);
        return THR_W'((k * full_scale) / 2);
    endfunction

endpackage

// File: rtl/amplitude_decoder_if.sv
// Sample stream in, recovered amplitude status out.
// Signal suffixes are from the decoder's point of view.
interface amplitude_decoder_if;
    import amp_pkg::*;

    logic [AMP_W-1:0] sample_i;
    logic             sample_valid_i;
    amp_code_e        amp_sel_o;
    logic             amp_valid_o;
    logic             amp_changed_o;
    logic             no_signal_o;
    logic [AMP_W-1:0] p2p_o;

    modport master (
        output sample_i, sample_valid_i,
        input  amp_sel_o, amp_valid_o, amp_changed_o, no_signal_o, p2p_o
    );

    modport slave (
        input  sample_i, sample_valid_i,
        output amp_sel_o, amp_valid_o, amp_changed_o, no_signal_o, p2p_o
    );

endinterface

// File: rtl/window_peak_tracker.sv
// Running max/min and sample count over a window of WINDOW accepted samples.
// load_i restarts the window, seeding it with the current sample if valid.
module window_peak_tracker
    import amp_pkg::*;
#(
    parameter int unsigned WINDOW = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [AMP_W-1:0] sample_i,
    output logic [AMP_W-1:0] max_o,
    output logic [AMP_W-1:0] min_o,
    output logic             last_o
);

    localparam int unsigned CntW = $clog2(WINDOW + 1);
    localparam logic [AMP_W-1:0] MinInit = '1;

    logic [CntW-1:0]  count_q, count_d;
    logic [AMP_W-1:0] max_q, max_d;
    logic [AMP_W-1:0] min_q, min_d;

    assign last_o = valid_i && !load_i && (count_q == CntW'(WINDOW - 1));
    assign max_o  = max_q;
    assign min_o  = min_q;

    always_comb begin
        count_d = count_q;
        max_d   = max_q;
        min_d   = min_q;
        if (load_i) begin
            if (valid_i) begin
                max_d   = sample_i;
                min_d   = sample_i;
                count_d = CntW'(1);
            end else begin
                max_d   = '0;
                min_d   = MinInit;
                count_d = '0;
            end
        end else if (valid_i) begin
            if (sample_i > max_q) max_d = sample_i;
            if (sample_i < min_q) min_d = sample_i;
            // Trackers keep the full window for EVAL; only the count wraps here.
            count_d = last_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            max_q   <= '0;
            min_q   <= MinInit;
        end else begin
            count_q <= count_d;
            max_q   <= max_d;
            min_q   <= min_d;
        end
    end

endmodule

// File: rtl/amplitude_decoder.sv
// Recovers the 2-bit gain code from peak-to-peak swing per window.
// A new code is adopted only when two consecutive valid windows agree.
module amplitude_decoder
    import amp_pkg::*;
#(
    parameter int unsigned WINDOW     = 256,
    parameter int unsigned FULL_SCALE = 255,
    parameter int unsigned MIN_P2P    = 32
) (
    input logic                clk,
    input logic                rst_n,
    amplitude_decoder_if.slave dec_if
);

    localparam logic [THR_W-1:0] T1 = thr(FULL_SCALE, 3);
    localparam logic [THR_W-1:0] T2 = thr(FULL_SCALE, 5);
    localparam logic [THR_W-1:0] T3 = thr(FULL_SCALE, 7);

    state_e           state_q;
    amp_code_e        amp_sel_q;
    amp_code_e        cand_q;
    logic             cand_ok_q;
    logic             amp_valid_q;
    logic             amp_changed_q;
    logic             no_signal_q;
    logic [AMP_W-1:0] p2p_q;

    logic [AMP_W-1:0] trk_max, trk_min;
    logic             trk_last;
    logic [AMP_W-1:0] p2p_w;
    amp_code_e        cls_w;
    logic             below_min_w;

    window_peak_tracker #(
        .WINDOW (WINDOW)
    ) u_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (state_q == StEval),
        .valid_i  (dec_if.sample_valid_i),
        .sample_i (dec_if.sample_i),
        .max_o    (trk_max),
        .min_o    (trk_min),
        .last_o   (trk_last)
    );

    // Never negative: the window always holds at least one sample.
    assign p2p_w       = trk_max - trk_min;
    assign below_min_w = 32'(p2p_w) < MIN_P2P;

    always_comb begin
        cls_w = AMP_X4;
        if ({1'b0, p2p_w} <= T1)      cls_w = AMP_X1;
        else if ({1'b0, p2p_w} <= T2) cls_w = AMP_X2;
        else if ({1'b0, p2p_w} <= T3) cls_w = AMP_X3;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StAcc;
            amp_sel_q     <= AMP_X1;
            cand_q        <= AMP_X1;
            cand_ok_q     <= 1'b0;
            amp_valid_q   <= 1'b0;
            amp_changed_q <= 1'b0;
            no_signal_q   <= 1'b1;
            p2p_q         <= '0;
        end else begin
            amp_valid_q   <= 1'b0;
            amp_changed_q <= 1'b0;
            case (state_q)
                StAcc: begin
                    if (trk_last) state_q <= StEval;
                end
                StEval: begin
                    state_q     <= StAcc;
                    amp_valid_q <= 1'b1;
                    p2p_q       <= p2p_w;
                    if (below_min_w) begin
                        no_signal_q <= 1'b1;
                        cand_ok_q   <= 1'b0;
                    end else begin
                        no_signal_q <= 1'b0;
                        if (cand_ok_q && (cls_w == cand_q)) begin
                            amp_sel_q     <= cls_w;
                            amp_changed_q <= (cls_w != amp_sel_q);
                        end
                        cand_q    <= cls_w;
                        cand_ok_q <= 1'b1;
                    end
                end
                default: state_q <= StAcc;
            endcase
        end
    end

    assign dec_if.amp_sel_o     = amp_sel_q;
    assign dec_if.amp_valid_o   = amp_valid_q;
    assign dec_if.amp_changed_o = amp_changed_q;
    assign dec_if.no_signal_o   = no_signal_q;
    assign dec_if.p2p_o         = p2p_q;

endmodule

// File: tb/tb_amplitude_decoder.sv
// Bench for amplitude_decoder: directed and random windows checked every cycle
// against a queue-based window model of the decoder's behaviour.
module tb_amplitude_decoder;
    import amp_pkg::*;

    localparam int unsigned WINDOW     = 256;
    localparam int unsigned FULL_SCALE = 255;
    localparam int unsigned MIN_P2P    = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    amplitude_decoder_if dut_if ();

    amplitude_decoder #(
        .WINDOW     (WINDOW),
        .FULL_SCALE (FULL_SCALE),
        .MIN_P2P    (MIN_P2P)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .dec_if (dut_if.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: raw samples of the open window plus expected outputs.
    int win_q[$];
    int wmax, wmin;
    bit pend;
    int e_sel, e_ns, e_p2p, e_valid, e_changed;
    int cand;
    bit cand_ok;

    function automatic int cls_of(input int p);
        if (p <= (3 * FULL_SCALE) / 2) return 0;
        if (p <= (5 * FULL_SCALE) / 2) return 1;
        if (p <= (7 * FULL_SCALE) / 2) return 2;
        return 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("amp_valid",   32'(dut_if.amp_valid_o),   32'(e_valid));
        chk("amp_changed", 32'(dut_if.amp_changed_o), 32'(e_changed));
        chk("amp_sel",     32'(dut_if.amp_sel_o),     32'(e_sel));
        chk("no_signal",   32'(dut_if.no_signal_o),   32'(e_ns));
        chk("p2p",         32'(dut_if.p2p_o),         32'(e_p2p));
    endtask

    task automatic model_reset();
        win_q.delete();
        pend      = 1'b0;
        e_sel     = 0;
        e_ns      = 1;
        e_p2p     = 0;
        e_valid   = 0;
        e_changed = 0;
        cand      = 0;
        cand_ok   = 1'b0;
    endtask

    // One clock: drive, let the edge happen, check, then record the accepted sample.
    task automatic step(input bit v, input int s);
        int c;
        dut_if.sample_valid_i = v;
        dut_if.sample_i       = 11'(s);
        @(posedge clk);
        #1;
        e_valid   = 0;
        e_changed = 0;
        if (pend) begin
            pend    = 1'b0;
            e_valid = 1;
            e_p2p   = wmax - wmin;
            if (e_p2p < int'(MIN_P2P)) begin
                e_ns    = 1;
                cand_ok = 1'b0;
            end else begin
                c    = cls_of(e_p2p);
                e_ns = 0;
                if (cand_ok && c == cand) begin
                    e_changed = (c != e_sel) ? 1 : 0;
                    e_sel     = c;
                end
                cand    = c;
                cand_ok = 1'b1;
            end
        end
        check_all();
        if (v) begin
            win_q.push_back(s);
            if (win_q.size() == int'(WINDOW)) begin
                wmax = 0;
                wmin = 2047;
                foreach (win_q[i]) begin
                    if (win_q[i] > wmax) wmax = win_q[i];
                    if (win_q[i] < wmin) wmin = win_q[i];
                end
                win_q.delete();
                pend = 1'b1;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        model_reset();
        repeat (n) begin
            dut_if.sample_valid_i = 1'($urandom_range(0, 1));
            dut_if.sample_i       = 11'($urandom_range(0, 2047));
            @(posedge clk);
            #1;
            check_all();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int g;
        int n;
        bit v;
        dut_if.sample_valid_i = 1'b0;
        dut_if.sample_i       = '0;

        // Reset with toggling inputs.
        do_reset(4);

        // Ramp x3, continuous valid: first EVAL p2p=765, second confirms code 10.
        repeat (2) for (int i = 0; i < 256; i++) step(1'b1, i * 3);
        step(1'b0, 0);

        // Classification boundary at T1: 382 stays 00, 383 moves to 01.
        repeat (2) for (int i = 0; i < int'(WINDOW); i++) step(1'b1, (i % 2) * 382);
        step(1'b0, 0);
        repeat (2) for (int i = 0; i < int'(WINDOW); i++) step(1'b1, (i % 2) * 383);
        step(1'b0, 0);

        // Flat input is no-signal; the next x4 window alone must not change amp_sel.
        for (int i = 0; i < int'(WINDOW); i++) step(1'b1, 100);
        step(1'b0, 0);
        repeat (2) for (int i = 0; i < int'(WINDOW); i++) step(1'b1, (i % 2) * 1020);
        step(1'b0, 0);

        // Gapped 1-0-1 valid, then a sample in the EVAL cycle that becomes the next max.
        for (int i = 0; i < 2 * int'(WINDOW) - 1; i++) step(i % 2 == 0, 600 + (i % 4) * 25);
        step(1'b1, 1500);
        for (int i = 0; i < 2 * int'(WINDOW) - 2; i++) step(i % 2 == 0, 600 + (i % 4) * 25);
        step(1'b0, 0);
        step(1'b0, 0);

        // Random gains with random gaps.
        repeat (4) begin
            g = int'($urandom_range(1, 4));
            n = 0;
            while (n < int'(WINDOW)) begin
                v = ($urandom_range(0, 3) != 0);
                step(v, int'($urandom_range(0, 255)) * g);
                if (v) n++;
            end
        end
        repeat (3) step(1'b0, 0);

        // Reset mid-window at sample 100; the next window counts from scratch.
        for (int i = 0; i < 100; i++) step(1'b1, (i % 2) * 800);
        do_reset(3);
        for (int i = 0; i < int'(WINDOW); i++) step(1'b1, (i % 2) * 800);
        repeat (2) step(1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
